// File: rtl/stack_cpu_pkg.sv
// Shared types and constants for the stack_cpu compute block.
// Contents: data/address/instruction widths, default I/O addresses, opcode enum,
// instruction struct, and the signed-overflow helper used when OVF_ERROR_EN is defined.
package stack_cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 12;

  localparam logic [ADDR_W-1:0] DEF_X_ADDR = 8'hF8;
  localparam logic [ADDR_W-1:0] DEF_Y_ADDR = 8'hFF;

  typedef enum logic [3:0] {
    OP_PUSHC = 4'h0,
    OP_PUSH  = 4'h1,
    OP_POP   = 4'h2,
    OP_JUMP  = 4'h3,
    OP_JZ    = 4'h4,
    OP_JN    = 4'h5,
    OP_ADD   = 4'h6,
    OP_SUB   = 4'h7
  } opcode_e;

  // Opcode kept as raw bits so that undefined encodings 8..F can be decoded.
  typedef struct packed {
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
  } instr_t;

  // Signed overflow of a+b (or a-b): operand signs agree (differ for sub) and the
  // result sign differs from a.
  function automatic logic add_sub_ovf(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b,
                                       input logic [DATA_W-1:0] r,
                                       input logic              is_sub);
    logic signs_match;
    signs_match = (a[DATA_W-1] == b[DATA_W-1]);
    return (is_sub ? !signs_match : signs_match) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

endpackage

// File: rtl/stack_cpu_imem.sv
// Instruction memory for stack_cpu: 256 x 12-bit storage, read combinationally by PC.
// The array i_storage is loaded hierarchically by benches or boot logic.
// Ports:
//   addr  - instruction address (PC)
//   data  - instruction word at addr
module stack_cpu_imem
  import stack_cpu_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr,
  output logic [INSTR_W-1:0] data
);

  logic [INSTR_W-1:0] i_storage [0:255];

  assign data = i_storage[addr];

endmodule

// File: rtl/stack_cpu.sv
// stack_cpu: 8-bit single-cycle stack machine executing 12-bit instructions.
// Data space is 256 bytes of RAM with memory-mapped input X (read at X_ADDR) and
// registered output Y (written at Y_ADDR). A sticky error flag records overflow,
// underflow and undefined opcodes; a faulting instruction only advances the PC.
// Optional: define OVF_ERROR_EN to also flag signed overflow on ADD/SUB.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   X      - signed external input
//   Y      - signed registered output
//   error  - sticky error flag
module stack_cpu
  import stack_cpu_pkg::*;
#(
  parameter int unsigned       STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] X_ADDR      = DEF_X_ADDR,
  parameter logic [ADDR_W-1:0] Y_ADDR      = DEF_Y_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] X,
  output logic [DATA_W-1:0] Y,
  output logic              error
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              error_q, error_d;

  // Contents are not reset; only SP decides which entries are live.
  logic [DATA_W-1:0] stack_q [STACK_DEPTH];
  logic [DATA_W-1:0] ram_q   [256];

  logic [INSTR_W-1:0] instr_raw;
  instr_t             instr;
  logic [ADDR_W-1:0]  k;

  stack_cpu_imem instruction_memory (
    .addr (pc_q),
    .data (instr_raw)
  );

  assign instr = instr_t'(instr_raw);
  assign k     = instr.operand;

  logic [IDX_W-1:0]  idx_top, idx_sec, idx_push;
  logic [DATA_W-1:0] top_val, sec_val, mem_rd;
  logic              full, has1, has2;

  assign idx_top  = IDX_W'(sp_q - SP_W'(1));
  assign idx_sec  = IDX_W'(sp_q - SP_W'(2));
  assign idx_push = IDX_W'(sp_q);
  assign top_val  = stack_q[idx_top];
  assign sec_val  = stack_q[idx_sec];
  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign has1     = (sp_q != '0);
  assign has2     = (sp_q >= SP_W'(2));

  always_comb begin
    mem_rd = ram_q[k];
    if (k == X_ADDR) begin
      mem_rd = X;
    end else if (k == Y_ADDR) begin
      mem_rd = y_q;
    end
  end

  logic [DATA_W-1:0] sum, diff;
  assign sum  = sec_val + top_val;
  assign diff = sec_val - top_val;

  logic              err;
  logic              stk_we;
  logic [IDX_W-1:0]  stk_widx;
  logic [DATA_W-1:0] stk_wdata;
  logic              ram_we;

  always_comb begin
    pc_d      = pc_q + ADDR_W'(1);
    sp_d      = sp_q;
    y_d       = y_q;
    err       = 1'b0;
    stk_we    = 1'b0;
    stk_widx  = idx_push;
    stk_wdata = k;
    ram_we    = 1'b0;
    unique case (instr.opcode)
      OP_PUSHC, OP_PUSH: begin
        if (full) begin
          err = 1'b1;
        end else begin
          stk_we    = 1'b1;
          stk_wdata = (instr.opcode == OP_PUSH) ? mem_rd : k;
          sp_d      = sp_q + SP_W'(1);
        end
      end
      OP_POP: begin
        if (!has1) begin
          err = 1'b1;
        end else begin
          sp_d = sp_q - SP_W'(1);
          if (k == Y_ADDR) begin
            y_d = top_val;
          end else if (k != X_ADDR) begin
            ram_we = 1'b1;
          end
        end
      end
      OP_JUMP: pc_d = k;
      OP_JZ, OP_JN: begin
        if (!has1) begin
          err = 1'b1;
        end else begin
          sp_d = sp_q - SP_W'(1);
          if ((instr.opcode == OP_JZ) ? (top_val == '0) : top_val[DATA_W-1]) begin
            pc_d = k;
          end
        end
      end
      OP_ADD, OP_SUB: begin
        if (!has2) begin
          err = 1'b1;
        end else begin
          // Two pops and one push collapse into a write over the deeper operand.
          sp_d      = sp_q - SP_W'(1);
          stk_we    = 1'b1;
          stk_widx  = idx_sec;
          stk_wdata = (instr.opcode == OP_SUB) ? diff : sum;
`ifdef OVF_ERROR_EN
          err = add_sub_ovf(sec_val, top_val, stk_wdata, instr.opcode == OP_SUB);
`endif
        end
      end
      default: err = 1'b1;
    endcase
    error_d = error_q | err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      sp_q    <= '0;
      y_q     <= '0;
      error_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      y_q     <= y_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stk_we) begin
      stack_q[stk_widx] <= stk_wdata;
    end
    if (ram_we) begin
      ram_q[k] <= top_val;
    end
  end

  assign Y     = y_q;
  assign error = error_q;

endmodule

// File: tb/tb_stack_cpu.sv
// Self-checking bench for stack_cpu: directed scenarios plus random programs checked
// against a queue-based behavioural model of the instruction set.
module tb_stack_cpu;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] X = 8'h00;
  logic [7:0] Y;
  logic       error;

  stack_cpu cpu (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .Y     (Y),
    .error (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  localparam int DEPTH = 8;
  localparam logic [11:0] MAIN [12] = '{12'h1F8, 12'h017, 12'h600, 12'h2AA, 12'h1AA, 12'h1AA,
                                        12'h600, 12'h00C, 12'h700, 12'h2FF, 12'h00A, 12'h30A};

  // Reference model state
  logic [11:0] m_prog [256];
  logic [7:0]  m_mem  [256];
  logic [7:0]  m_stk  [$];
  logic [7:0]  m_pc;
  logic [7:0]  m_y;
  logic        m_err;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a == 8'hF8) return X;
    if (a == 8'hFF) return m_y;
    return m_mem[a];
  endfunction

  task automatic m_reset();
    m_pc = 8'h00;
    m_y  = 8'h00;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic m_step();
    logic [3:0] op;
    logic [7:0] kk, a, b, v, nxt;
    int s;
    op  = m_prog[m_pc][11:8];
    kk  = m_prog[m_pc][7:0];
    nxt = m_pc + 8'd1;
    case (op)
      4'h0, 4'h1: begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back(op == 4'h0 ? kk : m_read(kk));
      end
      4'h2: begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else begin
          v = m_stk.pop_back();
          if (kk == 8'hFF) m_y = v;
          else if (kk != 8'hF8) m_mem[kk] = v;
        end
      end
      4'h3: nxt = kk;
      4'h4, 4'h5: begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else begin
          v = m_stk.pop_back();
          if ((op == 4'h4 && v == 8'h00) || (op == 4'h5 && v[7])) nxt = kk;
        end
      end
      4'h6, 4'h7: begin
        if (m_stk.size() < 2) m_err = 1'b1;
        else begin
          b = m_stk.pop_back();
          a = m_stk.pop_back();
          if (op == 4'h6) s = int'($signed(a)) + int'($signed(b));
          else s = int'($signed(a)) - int'($signed(b));
          m_stk.push_back(s[7:0]);
`ifdef OVF_ERROR_EN
          if (s > 127 || s < -128) m_err = 1'b1;
`endif
        end
      end
      default: m_err = 1'b1;
    endcase
    m_pc = nxt;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) m_prog[i] = 12'h000;
  endtask

  task automatic load_dut();
    for (int i = 0; i < 256; i++) cpu.instruction_memory.i_storage[i] = m_prog[i];
  endtask

  // Pulse reset between edges; returns a few ns after a rising edge, reset released.
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    m_reset();
  endtask

  // One instruction: drive X at the falling edge, advance the model, sample after the edge.
  task automatic step(input logic [7:0] xv);
    @(negedge clk);
    X = xv;
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks += 4;
    if (cpu.pc_q !== 8'h00) begin failures++; $display("FAIL reset_pc: got %0h want 0", cpu.pc_q); end
    if (cpu.sp_q !== 4'd0) begin failures++; $display("FAIL reset_sp: got %0d want 0", cpu.sp_q); end
    if (Y !== 8'h00) begin failures++; $display("FAIL reset_y: got %0h want 0", Y); end
    if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error); end
  endtask

  task automatic test_program(input logic [7:0] xv, input logic [7:0] exp_y);
    clear_prog();
    for (int i = 0; i < 12; i++) m_prog[i] = MAIN[i];
    load_dut();
    do_reset();
    repeat (10) step(xv);
    checks += 2;
    if (Y !== exp_y) begin failures++; $display("FAIL prog_y x=%0h: got %0h want %0h", xv, Y, exp_y); end
    if (error !== 1'b0) begin failures++; $display("FAIL prog_error: got %b want 0", error); end
  endtask

  // Continues from test_program(5): loop pushes on edges 11,13,..; 9th push is edge 27.
  task automatic test_stack_overflow();
    repeat (16) step(8'h05);
    checks += 2;
    if (error !== 1'b0) begin failures++; $display("FAIL ovfl_pre_error: got %b want 0", error); end
    if (cpu.sp_q !== 4'd8) begin failures++; $display("FAIL ovfl_pre_sp: got %0d want 8", cpu.sp_q); end
    step(8'h05);
    checks += 2;
    if (error !== 1'b1) begin failures++; $display("FAIL ovfl_error: got %b want 1", error); end
    if (cpu.sp_q !== 4'd8) begin failures++; $display("FAIL ovfl_sp: got %0d want 8", cpu.sp_q); end
    repeat (6) step(8'h05);
    checks += 2;
    if (error !== 1'b1) begin failures++; $display("FAIL ovfl_sticky: got %b want 1", error); end
    if (Y !== 8'd44) begin failures++; $display("FAIL ovfl_y: got %0h want 2c", Y); end
  endtask

  task automatic test_add_empty();
    clear_prog();
    m_prog[0] = 12'h600;
    load_dut();
    do_reset();
    step(8'h00);
    checks += 3;
    if (error !== 1'b1) begin failures++; $display("FAIL add_empty_error: got %b want 1", error); end
    if (cpu.sp_q !== 4'd0) begin failures++; $display("FAIL add_empty_sp: got %0d want 0", cpu.sp_q); end
    if (cpu.pc_q !== 8'h01) begin failures++; $display("FAIL add_empty_pc: got %0h want 1", cpu.pc_q); end
  endtask

  task automatic test_branches();
    logic [11:0] i0 [4];
    logic [11:0] i1 [4];
    logic [7:0]  ep [4];
    i0 = '{12'h000, 12'h001, 12'h080, 12'h07F};
    i1 = '{12'h420, 12'h420, 12'h530, 12'h530};
    ep = '{8'h20, 8'h02, 8'h30, 8'h02};
    for (int t = 0; t < 4; t++) begin
      clear_prog();
      m_prog[0] = i0[t];
      m_prog[1] = i1[t];
      load_dut();
      do_reset();
      step(8'h00);
      step(8'h00);
      checks += 3;
      if (cpu.pc_q !== ep[t]) begin
        failures++; $display("FAIL branch%0d_pc: got %0h want %0h", t, cpu.pc_q, ep[t]);
      end
      if (cpu.sp_q !== 4'd0) begin
        failures++; $display("FAIL branch%0d_sp: got %0d want 0", t, cpu.sp_q);
      end
      if (error !== 1'b0) begin
        failures++; $display("FAIL branch%0d_error: got %b want 0", t, error);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_prog();
    for (int i = 0; i < 12; i++) m_prog[i] = MAIN[i];
    load_dut();
    do_reset();
    repeat (30) step(8'h05);
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (cpu.pc_q !== 8'h00) begin failures++; $display("FAIL mid_reset_pc: got %0h want 0", cpu.pc_q); end
    if (cpu.sp_q !== 4'd0) begin failures++; $display("FAIL mid_reset_sp: got %0d want 0", cpu.sp_q); end
    if (Y !== 8'h00) begin failures++; $display("FAIL mid_reset_y: got %0h want 0", Y); end
    if (error !== 1'b0) begin failures++; $display("FAIL mid_reset_error: got %b want 0", error); end
    @(posedge clk);
    #2 reset = 1'b1;
    m_reset();
    repeat (10) step(8'h05);
    checks += 2;
    if (Y !== 8'd44) begin failures++; $display("FAIL restart_y: got %0h want 2c", Y); end
    if (error !== 1'b0) begin failures++; $display("FAIL restart_error: got %b want 0", error); end
  endtask

  task automatic test_signed_overflow();
    logic exp_err;
`ifdef OVF_ERROR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    clear_prog();
    m_prog[0] = 12'h07F;
    m_prog[1] = 12'h001;
    m_prog[2] = 12'h600;
    load_dut();
    do_reset();
    repeat (3) step(8'h00);
    checks += 3;
    if (cpu.sp_q !== 4'd1) begin failures++; $display("FAIL ovf_sp: got %0d want 1", cpu.sp_q); end
    if (cpu.stack_q[0] !== 8'h80) begin
      failures++; $display("FAIL ovf_top: got %0h want 80", cpu.stack_q[0]);
    end
    if (error !== exp_err) begin failures++; $display("FAIL ovf_error: got %b want %b", error, exp_err); end
  endtask

  task automatic test_random();
    logic [7:0] addrs [6];
    logic [3:0] op;
    logic [7:0] kk;
    addrs = '{8'hF8, 8'hFF, 8'h10, 8'h11, 8'h12, 8'h13};
    for (int r = 0; r < 4; r++) begin
      clear_prog();
      // Prologue defines every RAM byte that random code may read.
      for (int i = 0; i < 4; i++) begin
        m_prog[2*i]   = {4'h0, 8'($urandom)};
        m_prog[2*i+1] = {4'h2, 8'(8'h10 + i)};
      end
      for (int i = 8; i < 256; i++) begin
        op = 4'($urandom_range(0, 8));
        if (op == 4'h8) op = 4'($urandom_range(8, 15));
        if (op == 4'h1 || op == 4'h2) kk = addrs[$urandom_range(0, 5)];
        else kk = 8'($urandom);
        m_prog[i] = {op, kk};
      end
      load_dut();
      do_reset();
      for (int c = 0; c < 200; c++) begin
        step(8'($urandom));
        checks += 4;
        if (cpu.pc_q !== m_pc) begin
          failures++; $display("FAIL rnd%0d_c%0d_pc: got %0h want %0h", r, c, cpu.pc_q, m_pc);
        end
        if (int'(cpu.sp_q) !== m_stk.size()) begin
          failures++; $display("FAIL rnd%0d_c%0d_sp: got %0d want %0d", r, c, cpu.sp_q, m_stk.size());
        end
        if (Y !== m_y) begin
          failures++; $display("FAIL rnd%0d_c%0d_y: got %0h want %0h", r, c, Y, m_y);
        end
        if (error !== m_err) begin
          failures++; $display("FAIL rnd%0d_c%0d_error: got %b want %b", r, c, error, m_err);
        end
        if (m_stk.size() > 0 && int'(cpu.sp_q) == m_stk.size()) begin
          checks++;
          if (cpu.stack_q[cpu.sp_q - 1] !== m_stk[m_stk.size()-1]) begin
            failures++;
            $display("FAIL rnd%0d_c%0d_top: got %0h want %0h", r, c,
                     cpu.stack_q[cpu.sp_q - 1], m_stk[m_stk.size()-1]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_program(8'h05, 8'd44);
    test_stack_overflow();
    test_program(8'h9C, 8'd90);
    test_add_empty();
    test_branches();
    test_reset_mid();
    test_signed_overflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_cpu.md
Name: stack_cpu

Overview:
- 8-bit single-cycle stack machine executing 12-bit instructions from an internal 256-entry instruction memory.
- Data is a 256-byte address space: RAM plus two memory-mapped I/O locations, input X and output Y.
- Top-level compute block; the instruction memory is loaded hierarchically by benches/boot logic.
- Sticky error flag reports illegal operations.

Parameters:
- STACK_DEPTH, 8, number of 8-bit operand-stack entries.
- X_ADDR, 8'hF8, data address whose read returns port X.
- Y_ADDR, 8'hFF, data address whose write updates port Y.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- X  input  8  signed external input, read via X_ADDR.
- Y  output  8  signed registered output, written via Y_ADDR.
- error  output  1  sticky error flag.

Behaviour:
- Reset (reset=0, async): PC=0, SP=0 (stack empty), Y=0, error=0. Data RAM and stack contents are not cleared.
- Instruction format: [11:8] opcode, [7:0] operand K.
- One instruction completes per rising edge. The first edge after reset release executes PC=0. Default next PC is PC+1, 8-bit wrap (255 -> 0).
- Opcodes:
  - 0 PUSHC: push K.
  - 1 PUSH: push mem[K].
  - 2 POP: pop into mem[K].
  - 3 JUMP: PC=K.
  - 4 JZ: pop v; if v==0 then PC=K.
  - 5 JN: pop v; if v[7]==1 then PC=K.
  - 6 ADD: pop b, pop a, push a+b.
  - 7 SUB: pop b, pop a, push a-b (a is the deeper operand).
  - 8..F: undefined.
- Arithmetic: 8-bit two's complement, wrap-around, no flags.
- Memory map:
  - Read of X_ADDR returns X sampled that cycle.
  - Read of Y_ADDR returns the current Y register.
  - Write to Y_ADDR updates Y at the clock edge; RAM at that address is not written.
  - Write to X_ADDR is discarded.
  - All other addresses are RAM, read combinationally and written at the edge.
- Error conditions (each sets error=1, which holds until reset):
  - push with SP==STACK_DEPTH (overflow);
  - POP/JZ/JN with SP==0, or ADD/SUB with SP<2 (underflow);
  - undefined opcode.
- On any error: the instruction has no effect on the stack, memory, Y, or branch decision; PC still advances to PC+1. Execution continues after an error.
- Simultaneous events: a read of X_ADDR and a change of X in the same cycle use the value present before the edge.

Optional Feature:
- Macro OVF_ERROR_EN.
- Defined: signed overflow on ADD/SUB also sets error. Overflow means operands have the same sign for ADD (opposite signs for SUB) and the result sign differs from a. The result is still pushed.
- Undefined: ADD/SUB never affect error.

Decomposition:
- Package stack_cpu_pkg:
  - opcode enum (OP_PUSHC..OP_SUB);
  - instruction typedef {opcode[3:0], operand[7:0]};
  - X_ADDR/Y_ADDR default constants;
  - widths (DATA_W=8, ADDR_W=8, INSTR_W=12).
- One sub-module: instruction ROM/RAM, instance name instruction_memory, containing reg array i_storage[0:255] of 12 bits, combinational read by PC. The hierarchical path cpu.instruction_memory.i_storage must remain loadable.
- Stack, data RAM and control stay in the top module.

Test Plan:
- Load program: PUSH F8, PUSHC 17, ADD, POP AA, PUSH AA, PUSH AA, ADD, PUSHC 0C, SUB, POP FF, PUSHC 0A, JUMP 0A. With X=5 -> Y=44 at the 10th edge after reset release, error=0.
- Same program with X=-100 -> Y=90 (wrap), error=0.
- Continue the same program -> the loop pushes every 2 cycles; the 9th push (27th edge) sets error=1; error stays 1 and Y stays unchanged.
- ADD with empty stack -> error=1, SP stays 0, PC=1.
- PUSHC 0, JZ 20 -> PC=0x20, SP=0.
- PUSHC 1, JZ 20 -> PC=2.
- PUSHC 0x80, JN 30 -> PC=0x30.
- Assert reset mid-program -> Y=0, error=0, PC=0 immediately (asynchronous); execution restarts at address 0 after release.
- OVF_ERROR_EN defined: PUSHC 7F, PUSHC 01, ADD -> top=0x80, error=1. Undefined: same program -> top=0x80, error=0.
